// File: rtl/spi_reg_ctrl.sv
// Register-write controller: validates decoded SPI frames and commits them into five config registers.
// Define SPI_REG_ERR_CNT_EN to add the saturating rejected-frame counter on err_count.
module spi_reg_ctrl #(
  parameter int MAX_ADDR       = 4,
  parameter int SYNC_DUTY      = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_valid,
  output logic        frame_ready,
  input  logic [15:0] frame_data,
  input  logic        period_end,
  output logic [7:0]  en_reg_out_7_0,
  output logic [7:0]  en_reg_out_15_8,
  output logic [7:0]  en_reg_pwm_7_0,
  output logic [7:0]  en_reg_pwm_15_8,
  output logic [7:0]  pwm_duty_cycle,
  output logic        busy,
  output logic        wr_reject
`ifdef SPI_REG_ERR_CNT_EN
  ,
  output logic [7:0]  err_count
`endif
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DECODE, WAIT_PERIOD, COMMIT} state_t;

  state_t        state;
  logic [15:0]   hold;
  logic [CW-1:0] wait_cnt;

  logic       hold_rw;
  logic [6:0] hold_addr;
  logic [7:0] hold_data;
  logic       frame_bad;
  logic       duty_sync;

  assign hold_rw   = hold[15];
  assign hold_addr = hold[14:8];
  assign hold_data = hold[7:0];
  assign frame_bad = !hold_rw || (hold_addr > 7'(MAX_ADDR));
  assign duty_sync = (hold_addr == 7'd4) && (SYNC_DUTY != 0);

  assign frame_ready = (state == IDLE);
  assign busy        = (state != IDLE);

  // Only one frame is ever in flight, so a single holding register is enough.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      hold            <= '0;
      wait_cnt        <= '0;
      wr_reject       <= 1'b0;
      en_reg_out_7_0  <= 8'h00;
      en_reg_out_15_8 <= 8'h00;
      en_reg_pwm_7_0  <= 8'h00;
      en_reg_pwm_15_8 <= 8'h00;
      pwm_duty_cycle  <= 8'h00;
`ifdef SPI_REG_ERR_CNT_EN
      err_count       <= 8'h00;
`endif
    end else begin
      wr_reject <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_valid) begin
            hold  <= frame_data;
            state <= DECODE;
          end
        end
        DECODE: begin
          if (frame_bad) begin
            wr_reject <= 1'b1;
`ifdef SPI_REG_ERR_CNT_EN
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
`endif
            state <= IDLE;
          end else if (duty_sync) begin
            wait_cnt <= '0;
            state    <= WAIT_PERIOD;
          end else begin
            state <= COMMIT;
          end
        end
        // A period_end coinciding with the timeout still yields a single commit.
        WAIT_PERIOD: begin
          if (period_end || (wait_cnt == CNT_LAST)) begin
            state <= COMMIT;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        COMMIT: begin
          case (hold_addr)
            7'd0:    en_reg_out_7_0  <= hold_data;
            7'd1:    en_reg_out_15_8 <= hold_data;
            7'd2:    en_reg_pwm_7_0  <= hold_data;
            7'd3:    en_reg_pwm_15_8 <= hold_data;
            7'd4:    pwm_duty_cycle  <= hold_data;
            default: ;
          endcase
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Scoreboard bench for spi_reg_ctrl: stimulus queues expected register snapshots, a negedge monitor checks them.
module tb_spi_reg_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_valid = 1'b0;
  logic [15:0] frame_data = 16'h0000;
  logic        period_end = 1'b0;
  logic        frame_ready, busy, wr_reject;
  logic [7:0]  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
`ifdef SPI_REG_ERR_CNT_EN
  logic [7:0]  err_count;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int e_cyc = 0;
  logic [7:0] exp_regs [5];

  typedef struct packed {
    logic [39:0] regs;
    logic        rej;
  } snap_t;
  snap_t exp_q[$];

  spi_reg_ctrl #(
    .MAX_ADDR(4),
    .SYNC_DUTY(1),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .frame_data(frame_data),
    .period_end(period_end),
    .en_reg_out_7_0(en_reg_out_7_0),
    .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0),
    .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle),
    .busy(busy),
    .wr_reject(wr_reject)
`ifdef SPI_REG_ERR_CNT_EN
    ,
    .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [39:0] cur_regs();
    return {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0, en_reg_out_15_8, en_reg_out_7_0};
  endfunction

  function automatic logic [39:0] model_regs();
    return {exp_regs[4], exp_regs[3], exp_regs[2], exp_regs[1], exp_regs[0]};
  endfunction

  task automatic checkOutput(input string name, input logic [39:0] act, input logic [39:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: any register change or reject pulse consumes exactly one scoreboard entry.
  logic [39:0] prev_regs = '0;
  always @(negedge clk) begin
    snap_t s;
    if (!rst_n) begin
      prev_regs = cur_regs();
    end else if (wr_reject || (cur_regs() != prev_regs)) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_event actual regs=%h rej=%b required none", cur_regs(), wr_reject);
      end else begin
        s = exp_q.pop_front();
        checkOutput("sb_regs", cur_regs(), s.regs);
        checkOutput("sb_reject", {39'b0, wr_reject}, {39'b0, s.rej});
      end
      prev_regs = cur_regs();
    end
  end

  task automatic applyStimulus(input logic [15:0] f, input logic rej, input int idx,
                               input logic [7:0] val, input logic keep_valid, input logic push);
    snap_t s;
    if (push) begin
      if (!rej) exp_regs[idx] = val;
      s.regs = model_regs();
      s.rej  = rej;
      exp_q.push_back(s);
    end
    @(negedge clk);
    frame_valid = 1'b1;
    frame_data  = f;
    for (int i = 0; i < 50 && !frame_ready; i++) @(negedge clk);
    if (!frame_ready) begin
      checks++;
      failures++;
      $display("[TB] FAIL handshake_timeout actual ready=0 required ready=1");
    end
    @(posedge clk);
    #1 e_cyc = cyc;
    @(negedge clk);
    if (!keep_valid) frame_valid = 1'b0;
  endtask

  task automatic at_neg(input int k);
    while (cyc < e_cyc + k) @(negedge clk);
  endtask

  int first_e;

  initial begin
    for (int i = 0; i < 5; i++) exp_regs[i] = 8'h00;

    repeat (3) @(negedge clk);
    checkOutput("reset_regs", cur_regs(), 40'h0);
    checkOutput("reset_busy_ready_rej", {37'b0, busy, frame_ready, wr_reject}, {37'b0, 3'b010});
    rst_n = 1'b1;
    @(negedge clk);

    // Immediate write to reg 1 lands at E+2.
    applyStimulus(16'h8155, 1'b0, 1, 8'h55, 1'b0, 1'b1);
    at_neg(1);
    checkOutput("t1_before_commit", {32'b0, en_reg_out_15_8}, 40'h00);
    at_neg(2);
    checkOutput("t1_commit", {32'b0, en_reg_out_15_8}, 40'h55);
    checkOutput("t1_idle", {38'b0, busy, frame_ready}, {38'b0, 2'b01});

    applyStimulus(16'h8012, 1'b0, 0, 8'h12, 1'b0, 1'b1);
    applyStimulus(16'h8234, 1'b0, 2, 8'h34, 1'b0, 1'b1);
    applyStimulus(16'h83C5, 1'b0, 3, 8'hC5, 1'b0, 1'b1);

    // Read frame, then out-of-range and far-out-of-range addresses are rejected.
    applyStimulus(16'h0233, 1'b1, 0, 8'h00, 1'b0, 1'b1);
    at_neg(1);
    checkOutput("t2_reject_pulse", {39'b0, wr_reject}, 40'h1);
    at_neg(2);
    checkOutput("t2_reject_done", {38'b0, wr_reject, frame_ready}, {38'b0, 2'b01});
    applyStimulus(16'h85AA, 1'b1, 0, 8'h00, 1'b0, 1'b1);
    applyStimulus(16'hFF00, 1'b1, 0, 8'h00, 1'b0, 1'b1);
    at_neg(3);
`ifdef SPI_REG_ERR_CNT_EN
    checkOutput("t2_err_count", {32'b0, err_count}, 40'h3);
`endif

    // Synced duty write committed one edge after the edge that samples period_end.
    applyStimulus(16'h8480, 1'b0, 4, 8'h80, 1'b0, 1'b1);
    at_neg(3);
    checkOutput("t3_waiting", {31'b0, busy, pwm_duty_cycle}, {31'b0, 1'b1, 8'h00});
    at_neg(4);
    period_end = 1'b1;
    at_neg(5);
    period_end = 1'b0;
    checkOutput("t3_not_yet", {32'b0, pwm_duty_cycle}, 40'h00);
    at_neg(6);
    checkOutput("t3_commit", {31'b0, busy, pwm_duty_cycle}, {31'b0, 1'b0, 8'h80});

    // A pulse while idle must not be remembered.
    @(negedge clk);
    period_end = 1'b1;
    @(negedge clk);
    period_end = 1'b0;

    // Forced commit after 8 wait cycles.
    applyStimulus(16'h8440, 1'b0, 4, 8'h40, 1'b0, 1'b1);
    at_neg(9);
    checkOutput("t4_before_timeout", {31'b0, busy, pwm_duty_cycle}, {31'b0, 1'b1, 8'h80});
    at_neg(10);
    checkOutput("t4_forced_commit", {31'b0, busy, pwm_duty_cycle}, {31'b0, 1'b0, 8'h40});

    // period_end coinciding with the timeout edge.
    applyStimulus(16'h8422, 1'b0, 4, 8'h22, 1'b0, 1'b1);
    at_neg(8);
    period_end = 1'b1;
    at_neg(9);
    period_end = 1'b0;
    checkOutput("t4b_before", {32'b0, pwm_duty_cycle}, 40'h40);
    at_neg(10);
    checkOutput("t4b_single_commit", {31'b0, busy, pwm_duty_cycle}, {31'b0, 1'b0, 8'h22});

    // frame_valid held high across two back-to-back frames.
    applyStimulus(16'h80F0, 1'b0, 0, 8'hF0, 1'b1, 1'b1);
    first_e = e_cyc;
    applyStimulus(16'h8301, 1'b0, 3, 8'h01, 1'b0, 1'b1);
    checkOutput("t5_accept_spacing", 40'(e_cyc - first_e), 40'd3);
    at_neg(2);
    checkOutput("t5_regs", cur_regs(), {8'h22, 8'h01, 8'h34, 8'h55, 8'hF0});

    // Reset during WAIT_PERIOD discards the pending duty.
    applyStimulus(16'h84C3, 1'b0, 4, 8'hC3, 1'b0, 1'b0);
    at_neg(4);
    #2 rst_n = 1'b0;
    for (int i = 0; i < 5; i++) exp_regs[i] = 8'h00;
    #1;
    checkOutput("t6_reset_ctrl", {38'b0, busy, frame_ready}, {38'b0, 2'b01});
    checkOutput("t6_reset_regs", cur_regs(), 40'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    period_end = 1'b1;
    @(negedge clk);
    period_end = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("t6_no_late_commit", {31'b0, busy, pwm_duty_cycle}, {31'b0, 1'b0, 8'h00});

    repeat (5) @(negedge clk);
    checkOutput("queue_drained", 40'(exp_q.size()), 40'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
